// File: rtl/branch_pc_redirect_if.sv
// branch_pc_redirect_if: execute-to-fetch redirect bus and the PC/status it returns
interface branch_pc_redirect_if #(parameter int ADDR_W = 32);
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              halt_req;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              flush;
    logic              misalign_err;
    logic [15:0]       redirect_cnt;
    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, halt_req,
        input  pc, pc_valid, flush, misalign_err, redirect_cnt
    );
    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, halt_req,
        output pc, pc_valid, flush, misalign_err, redirect_cnt
    );
endinterface

// File: rtl/branch_pc_redirect.sv
// branch_pc_redirect: owns the PC, applies branch/jump redirects and squashes wrong-path slots
module branch_pc_redirect #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter int                 PC_STEP      = 4,
    parameter int                 FLUSH_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    branch_pc_redirect_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;
    logic              r_flush;
    logic              r_mis;
    logic [15:0]       r_rcnt;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    assign w_redirect = bus.branch_taken | bus.jump;
    assign w_target   = bus.branch_taken ? bus.branch_target : bus.jump_target;
    assign bus.pc           = r_pc;
    assign bus.pc_valid     = r_valid;
    assign bus.flush        = r_flush;
    assign bus.misalign_err = r_mis;
    assign bus.redirect_cnt = r_rcnt;
    // PC/FSM update: rst > halt > stall > redirect > sequential; first post-reset edge only arms pc_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            r_mis   <= 1'b0;
            r_rcnt  <= '0;
        end else if (bus.halt_req) begin
            r_state <= HALT;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
        end else if (r_state != HALT && !bus.stall) begin
            if (!r_valid) begin
                r_valid <= 1'b1;
            end else if (r_state == RUN && w_redirect) begin
                r_pc    <= {w_target[ADDR_W-1:2], 2'b00};
                r_rcnt  <= r_rcnt + {15'd0, r_rcnt != 16'hFFFF};
                r_mis   <= r_mis | (w_target[1:0] != 2'b00);
                r_state <= FLUSH;
                r_cnt   <= 4'(FLUSH_CYCLES);
                r_flush <= 1'b1;
            end else begin
                r_pc <= r_pc + ADDR_W'(PC_STEP);
                if (r_state == FLUSH) begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RUN;
                        r_flush <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
